// File: rtl/nexys4io_axil_slave.sv
// -----------------------------------------------------------------------------
// nexys4io_axil_slave
// AXI4-Lite responder register bank for the Nexys4 I/O peripheral.
//   - Slots 0-3 (0x00..0x0C): read/write control registers, also driven
//     straight out on ctrl_regs = {reg3, reg2, reg1, reg0}.
//   - Slot 4 (0x10): synchronised switches, zero-extended, read-only.
//   - Slot 5 (0x14): synchronised buttons, zero-extended, read-only.
//   - Slots 6-7: read as zero. Writes to slots 4-7 are dropped but still
//     answered with OKAY.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET : bus clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address, data, response channels
//   S_AXI_AR* / S_AXI_R*            : read address and data channels
//   sw_in, btn_in : asynchronous board inputs (2-flop synchronised here)
//   ctrl_regs     : live contents of the four control registers
// Each channel allows a single outstanding transaction. AW and W are taken
// independently into hold registers; the register update and BVALID happen
// on the first edge where both are held.
// -----------------------------------------------------------------------------
module nexys4io_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int C_SW_WIDTH         = 16,
   parameter int C_BTN_WIDTH        = 5
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic [C_SW_WIDTH-1:0]           sw_in,
   input  logic [C_BTN_WIDTH-1:0]          btn_in,
   output logic [127:0]                    ctrl_regs
);

   // Write-side state
   logic                   aw_held_q, aw_held_d;
   logic [2:0]             aw_idx_q, aw_idx_d;
   logic                   w_held_q, w_held_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [3:0]             wstrb_q, wstrb_d;
   logic                   bvalid_q, bvalid_d;
   logic [3:0][31:0]       regs_q, regs_d;

   // Read-side state
   logic                   rvalid_q, rvalid_d;
   logic [31:0]            rdata_q, rdata_d;

   // Input synchronisers
   logic [C_SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
   logic [C_BTN_WIDTH-1:0] btn_meta_q, btn_sync_q;

   logic awready_s, wready_s, arready_s;
   logic aw_hs_s, w_hs_s, ar_hs_s, commit_s;
   logic unused_s;

   // Byte-lane merge: lane n of new_v replaces bits 8n+7:8n when strb[n] is set.
   function automatic logic [31:0] apply_strobes(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int n = 0; n < 4; n++) begin
         if (strb[n]) begin
            res[8*n +: 8] = new_v[8*n +: 8];
         end else begin
            res[8*n +: 8] = old_v[8*n +: 8];
         end
      end
      return res;
   endfunction

   // Word-slot read decode.
   function automatic logic [31:0] read_slot(input logic [2:0]             idx,
                                             input logic [3:0][31:0]       regs,
                                             input logic [C_SW_WIDTH-1:0]  sw_v,
                                             input logic [C_BTN_WIDTH-1:0] btn_v);
      logic [31:0] res;
      case (idx)
         3'd0:    res = regs[0];
         3'd1:    res = regs[1];
         3'd2:    res = regs[2];
         3'd3:    res = regs[3];
         3'd4:    res = {{(32-C_SW_WIDTH){1'b0}}, sw_v};
         3'd5:    res = {{(32-C_BTN_WIDTH){1'b0}}, btn_v};
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   // Ready terms are forced low combinationally while reset is asserted.
   assign awready_s = !aw_held_q && !bvalid_q && !S_AXI_ARESET;
   assign wready_s  = !w_held_q  && !bvalid_q && !S_AXI_ARESET;
   assign arready_s = !rvalid_q  && !S_AXI_ARESET;

   assign aw_hs_s  = S_AXI_AWVALID && awready_s;
   assign w_hs_s   = S_AXI_WVALID  && wready_s;
   assign ar_hs_s  = S_AXI_ARVALID && arready_s;
   assign commit_s = aw_held_q && w_held_q;

   assign S_AXI_AWREADY = awready_s;
   assign S_AXI_WREADY  = wready_s;
   assign S_AXI_ARREADY = arready_s;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign ctrl_regs     = regs_q;

   assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Next-state logic for both channels and the register bank.
   always_comb begin
      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      regs_d    = regs_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;

      if (commit_s) begin
         // Neither AW nor W can handshake here (both held), and BVALID is low.
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         if (aw_idx_q[2] == 1'b0) begin
            regs_d[aw_idx_q[1:0]] = apply_strobes(regs_q[aw_idx_q[1:0]], wdata_q, wstrb_q);
         end else begin
            regs_d = regs_q;
         end
      end else begin
         if (aw_hs_s) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[4:2];
         end else begin
            aw_held_d = aw_held_q;
         end
         if (w_hs_s) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
         end else begin
            w_held_d = w_held_q;
         end
         if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
         end else begin
            bvalid_d = bvalid_q;
         end
      end

      // Read uses regs_q, so a same-edge commit to the same slot returns the old value.
      if (ar_hs_s) begin
         rvalid_d = 1'b1;
         rdata_d  = read_slot(S_AXI_ARADDR[4:2], regs_q, sw_sync_q, btn_sync_q);
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end else begin
         rvalid_d = rvalid_q;
      end
   end

   // State registers and input synchronisers.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         aw_held_q  <= 1'b0;
         aw_idx_q   <= 3'd0;
         w_held_q   <= 1'b0;
         wdata_q    <= 32'h0000_0000;
         wstrb_q    <= 4'h0;
         bvalid_q   <= 1'b0;
         regs_q     <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'h0000_0000;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         btn_meta_q <= '0;
         btn_sync_q <= '0;
      end else begin
         aw_held_q  <= aw_held_d;
         aw_idx_q   <= aw_idx_d;
         w_held_q   <= w_held_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         regs_q     <= regs_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         sw_meta_q  <= sw_in;
         sw_sync_q  <= sw_meta_q;
         btn_meta_q <= btn_in;
         btn_sync_q <= btn_meta_q;
      end
   end

endmodule

// File: tb/tb_nexys4io_axil_slave.sv
// Self-checking bench for nexys4io_axil_slave. Inputs change and outputs are
// sampled on the falling clock edge; expected values come from a small
// register-map model (array of four words plus the switch/button values).
module tb_nexys4io_axil_slave;

   logic         clk = 1'b0;
   logic         rst;
   logic [4:0]   awaddr, araddr;
   logic [2:0]   awprot, arprot;
   logic         awvalid, wvalid, bready, arvalid, rready;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [31:0]  wdata, rdata;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic [15:0]  sw;
   logic [4:0]   btn;
   logic [127:0] ctrl_regs;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_regs [4];
   logic [15:0] sw_val;
   logic [4:0]  btn_val;

   always #5 clk = ~clk;

   nexys4io_axil_slave dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .sw_in(sw), .btn_in(btn), .ctrl_regs(ctrl_regs)
   );

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_read(input logic [4:0] addr);
      int slot;
      slot = int'(addr) / 4;
      if (slot < 4) return model_regs[slot];
      else if (slot == 4) return {16'h0000, sw_val};
      else if (slot == 5) return {27'h0, btn_val};
      else return 32'h0000_0000;
   endfunction

   task automatic model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int slot;
      logic [31:0] w;
      slot = int'(addr) / 4;
      if (slot < 4) begin
         w = model_regs[slot];
         for (int b = 0; b < 4; b++)
            if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
         model_regs[slot] = w;
      end
   endtask

   function automatic logic [127:0] model_ctrl();
      return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
   endfunction

   // ---------------- bus tasks ----------------
   task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
      bit aw_d, w_d;
      int cyc;
      aw_d = 1'b0; w_d = 1'b0; cyc = 0; resp = 2'bxx;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      while (!(aw_d && w_d) && cyc < 20) begin
         if (awvalid && awready) aw_d = 1'b1;
         if (wvalid && wready) w_d = 1'b1;
         @(negedge clk);
         cyc++;
         if (aw_d) awvalid = 1'b0;
         if (w_d)  wvalid  = 1'b0;
      end
      while (!bvalid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (!bvalid) begin
         $display("FAIL write_timeout addr=%h: bvalid=0, required 1 within 20 cycles", addr);
         n_fail++;
         awvalid = 1'b0; wvalid = 1'b0;
      end else begin
         resp = bresp;
      end
      @(negedge clk);
   endtask

   task automatic do_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int cyc;
      cyc = 0; data = 32'hxxxx_xxxx; resp = 2'bxx;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      while (!arready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      arvalid = 1'b0;
      while (!rvalid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (!rvalid) begin
         $display("FAIL read_timeout addr=%h: rvalid=0, required 1 within 20 cycles", addr);
         n_fail++;
      end else begin
         data = rdata;
         resp = rresp;
      end
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b00000) begin
         $display("FAIL reset_flags: aw/w/ar/b/r=%b required 00000", {awready, wready, arready, bvalid, rvalid});
         n_fail++;
      end
      n_checks++;
      if (rdata !== 32'h0 || ctrl_regs !== 128'h0) begin
         $display("FAIL reset_data: rdata=%h ctrl=%h required zero", rdata, ctrl_regs);
         n_fail++;
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
      @(negedge clk);
      n_checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         $display("FAIL reset_release_ready: aw/w/ar=%b required 111", {awready, wready, arready});
         n_fail++;
      end
   endtask

   task automatic test_rw();
      logic [31:0] datas [4];
      logic [31:0] rd;
      logic [1:0]  br, rr;
      datas = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
      for (int i = 0; i < 4; i++) begin
         do_write(5'(4*i), datas[i], 4'hF, br);
         model_write(5'(4*i), datas[i], 4'hF);
         do_read(5'(4*i), rd, rr);
         n_checks++;
         if (br !== 2'b00 || rr !== 2'b00) begin
            $display("FAIL rw_resp slot%0d: bresp=%b rresp=%b required 00", i, br, rr);
            n_fail++;
         end
         n_checks++;
         if (rd !== model_read(5'(4*i))) begin
            $display("FAIL rw_readback slot%0d: got %h required %h", i, rd, model_read(5'(4*i)));
            n_fail++;
         end
      end
      n_checks++;
      if (ctrl_regs !== 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF) begin
         $display("FAIL rw_ctrl_regs: got %h required BEEF0011DEAD0011ABCD00010101FFFF", ctrl_regs);
         n_fail++;
      end
   endtask

   task automatic test_order();
      logic [4:0]  addr;
      logic [31:0] data, rd;
      logic [1:0]  rr;
      for (int o = 0; o < 2; o++) begin
         addr = (o == 0) ? 5'h08 : 5'h0C;
         data = $urandom;
         @(negedge clk);
         bready = 1'b1; awaddr = addr; wdata = data; wstrb = 4'hF;
         if (o == 0) wvalid = 1'b1; else awvalid = 1'b1;
         for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin wvalid = 1'b0; awvalid = 1'b0; end
            n_checks++;
            if (bvalid !== 1'b0 || ((o == 0) ? wready : awready) !== 1'b0) begin
               $display("FAIL order%0d_wait c%0d: bvalid=%b held_ready=%b required 0 0", o, c, bvalid,
                        (o == 0) ? wready : awready);
               n_fail++;
            end
         end
         if (o == 0) awvalid = 1'b1; else wvalid = 1'b1;
         @(negedge clk);
         awvalid = 1'b0; wvalid = 1'b0;
         n_checks++;
         if (bvalid !== 1'b0) begin
            $display("FAIL order%0d_early: bvalid=%b required 0 right after second handshake", o, bvalid);
            n_fail++;
         end
         @(negedge clk);
         n_checks++;
         if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            $display("FAIL order%0d_commit: bvalid=%b bresp=%b required 1 00", o, bvalid, bresp);
            n_fail++;
         end
         model_write(addr, data, 4'hF);
         repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (bvalid !== 1'b0) begin
               $display("FAIL order%0d_once: bvalid=%b required 0 after response", o, bvalid);
               n_fail++;
            end
         end
         do_read(addr, rd, rr);
         n_checks++;
         if (rd !== model_read(addr)) begin
            $display("FAIL order%0d_readback: got %h required %h", o, rd, model_read(addr));
            n_fail++;
         end
      end
   endtask

   task automatic test_strobe();
      logic [31:0] rd;
      logic [1:0]  br, rr;
      do_write(5'h04, 32'hABCD0001, 4'hF, br);
      model_write(5'h04, 32'hABCD0001, 4'hF);
      do_write(5'h04, 32'h12345678, 4'b0101, br);
      model_write(5'h04, 32'h12345678, 4'b0101);
      do_read(5'h04, rd, rr);
      n_checks++;
      if (rd !== 32'hAB340078 || rd !== model_read(5'h04)) begin
         $display("FAIL strobe_merge: got %h required AB340078", rd);
         n_fail++;
      end
      do_write(5'h05, 32'hFFFFFFFF, 4'h0, br);
      do_read(5'h04, rd, rr);
      n_checks++;
      if (br !== 2'b00 || rd !== 32'hAB340078) begin
         $display("FAIL strobe_zero: bresp=%b data=%h required 00 AB340078", br, rd);
         n_fail++;
      end
   endtask

   task automatic test_status();
      logic [31:0] rd;
      logic [1:0]  br, rr;
      sw_val = 16'hA5C3; btn_val = 5'b10010;
      @(negedge clk);
      sw = sw_val; btn = btn_val;
      repeat (3) @(negedge clk);
      do_read(5'h10, rd, rr);
      n_checks++;
      if (rd !== 32'h0000A5C3) begin
         $display("FAIL status_sw: got %h required 0000A5C3", rd);
         n_fail++;
      end
      do_read(5'h14, rd, rr);
      n_checks++;
      if (rd !== 32'h00000012) begin
         $display("FAIL status_btn: got %h required 00000012", rd);
         n_fail++;
      end
      do_write(5'h10, 32'hFFFFFFFF, 4'hF, br);
      do_read(5'h10, rd, rr);
      n_checks++;
      if (br !== 2'b00 || rd !== 32'h0000A5C3 || ctrl_regs !== model_ctrl()) begin
         $display("FAIL status_ro_write: bresp=%b data=%h required 00 0000A5C3", br, rd);
         n_fail++;
      end
      do_read(5'h1B, rd, rr);
      n_checks++;
      if (rd !== 32'h0 || rr !== 2'b00) begin
         $display("FAIL status_unmapped: got %h rresp=%b required 0 00", rd, rr);
         n_fail++;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d1, d2, held;
      d1 = $urandom; d2 = $urandom;
      @(negedge clk);
      awaddr = 5'h0C; wdata = d1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b1) begin
         $display("FAIL bp_latency: bvalid=%b required 1 one edge after handshake", bvalid);
         n_fail++;
      end
      model_write(5'h0C, d1, 4'hF);
      awaddr = 5'h08; awvalid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
            $display("FAIL bp_b_hold c%0d: bvalid,bresp,awready,wready=%b required 10000", c,
                     {bvalid, bresp, awready, wready});
            n_fail++;
         end
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
         $display("FAIL bp_b_release: bvalid=%b awready=%b required 0 1", bvalid, awready);
         n_fail++;
      end
      @(negedge clk);
      awvalid = 1'b0;
      wdata = d2; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b1) begin
         $display("FAIL bp_second_write: bvalid=%b required 1", bvalid);
         n_fail++;
      end
      model_write(5'h08, d2, 4'hF);
      @(negedge clk);
      n_checks++;
      if (ctrl_regs !== model_ctrl()) begin
         $display("FAIL bp_ctrl: got %h required %h", ctrl_regs, model_ctrl());
         n_fail++;
      end
      // Read held under RREADY low
      araddr = 5'h0C; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      arvalid = 1'b0;
      held = model_read(5'h0C);
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (rvalid !== 1'b1 || rdata !== held || arready !== 1'b0 || rresp !== 2'b00) begin
            $display("FAIL bp_r_hold c%0d: rvalid=%b rdata=%h arready=%b required 1 %h 0", c, rvalid, rdata,
                     arready, held);
            n_fail++;
         end
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         $display("FAIL bp_r_release: rvalid=%b arready=%b required 0 1", rvalid, arready);
         n_fail++;
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] pre, nd, rd;
      logic [1:0]  rr;
      pre = model_read(5'h04);
      nd  = $urandom;
      @(negedge clk);
      awaddr = 5'h04; wdata = nd; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b0;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 5'h04; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      n_checks++;
      if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== pre) begin
         $display("FAIL simul_prewrite: rvalid=%b bvalid=%b rdata=%h required 1 1 %h", rvalid, bvalid, rdata, pre);
         n_fail++;
      end
      model_write(5'h04, nd, 4'hF);
      rready = 1'b1;
      @(negedge clk);
      do_read(5'h04, rd, rr);
      n_checks++;
      if (rd !== model_read(5'h04)) begin
         $display("FAIL simul_postwrite: got %h required %h", rd, model_read(5'h04));
         n_fail++;
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd;
      logic [1:0]  br, rr;
      @(negedge clk);
      awaddr = 5'h00; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (awready !== 1'b0 || wready !== 1'b0 || ctrl_regs !== 128'h0) begin
         $display("FAIL abort_in_reset: awready=%b wready=%b ctrl=%h required 0 0 0", awready, wready, ctrl_regs);
         n_fail++;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
      sw_val = 16'h0; btn_val = 5'h0; sw = 16'h0; btn = 5'h0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++;
         if (bvalid !== 1'b0 || ctrl_regs !== 128'h0) begin
            $display("FAIL abort_no_resp c%0d: bvalid=%b ctrl=%h required 0 0", c, bvalid, ctrl_regs);
            n_fail++;
         end
      end
      do_write(5'h00, 32'h5A5A_1234, 4'hF, br);
      model_write(5'h00, 32'h5A5A_1234, 4'hF);
      do_read(5'h00, rd, rr);
      n_checks++;
      if (br !== 2'b00 || rd !== 32'h5A5A_1234) begin
         $display("FAIL abort_fresh_write: bresp=%b data=%h required 00 5A5A1234", br, rd);
         n_fail++;
      end
   endtask

   task automatic test_random();
      logic [4:0]  addr;
      logic [31:0] data, rd;
      logic [3:0]  strb;
      logic [1:0]  resp;
      sw_val = 16'($urandom); btn_val = 5'($urandom);
      @(negedge clk);
      sw = sw_val; btn = btn_val;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         addr = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 0) begin
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            do_write(addr, data, strb, resp);
            model_write(addr, data, strb);
            n_checks++;
            if (resp !== 2'b00 || ctrl_regs !== model_ctrl()) begin
               $display("FAIL rand_write%0d addr=%h: bresp=%b ctrl=%h required 00 %h", i, addr, resp, ctrl_regs,
                        model_ctrl());
               n_fail++;
            end
         end else begin
            do_read(addr, rd, resp);
            n_checks++;
            if (resp !== 2'b00 || rd !== model_read(addr)) begin
               $display("FAIL rand_read%0d addr=%h: got %h rresp=%b required %h 00", i, addr, rd, resp,
                        model_read(addr));
               n_fail++;
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      awaddr = 5'h0; araddr = 5'h0; awprot = 3'h0; arprot = 3'h0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      wdata = 32'h0; wstrb = 4'h0; sw = 16'h0; btn = 5'h0;
      sw_val = 16'h0; btn_val = 5'h0;
      test_reset();
      test_rw();
      test_order();
      test_strobe();
      test_status();
      test_backpressure();
      test_simultaneous();
      test_reset_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nexys4io_axil_slave.md
Name: nexys4io_axil_slave

Overview:
AXI4-Lite responder (slave) register bank for the Nexys4 I/O peripheral. It is the target side of the bus that the AXI4-Lite master BFM drives in block-level simulation.
- Holds 4 read/write control registers, which drive LED/display outputs.
- Exposes 2 read-only status registers: synchronised switches and buttons.
- Sits between the processor interconnect and the board I/O logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word slots.
C_SW_WIDTH, 16, switch input width.
C_BTN_WIDTH, 5, button input width.

Ports:
S_AXI_ACLK  in  1  bus clock, rising edge.
S_AXI_ARESET  in  1  reset: asynchronous, active-high.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write-address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte-lane strobes.
S_AXI_WVALID/S_AXI_WREADY  in/out  1  write-data handshake.
S_AXI_BRESP  out  2  write response; always 2'b00.
S_AXI_BVALID/S_AXI_BREADY  out/in  1  write-response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read-address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response; always 2'b00.
S_AXI_RVALID/S_AXI_RREADY  out/in  1  read-data handshake.
sw_in  in  C_SW_WIDTH  asynchronous switch inputs.
btn_in  in  C_BTN_WIDTH  asynchronous button inputs.
ctrl_regs  out  128  {reg3,reg2,reg1,reg0}, direct register contents.

Behaviour:
- Word decode: index = AxADDR[4:2]; AxADDR[1:0] ignored.
  - Slots 0-3: RW.
  - Slot 4: sw_sync, zero-extended; RO.
  - Slot 5: btn_sync, zero-extended; RO.
  - Slots 6-7: read 0.
  - Writes to slots 4-7 are discarded; response is still OKAY.
- Reset (async assert; deassert sampled on clock):
  - reg0-3 = 0; sync flops = 0.
  - BVALID = RVALID = 0; RDATA = 0.
  - AWREADY = WREADY = ARREADY = 0 while reset is high.
- Write channel (single outstanding transaction):
  - AWREADY = !aw_held && !BVALID && !reset; WREADY = !w_held && !BVALID && !reset.
  - AW and W are accepted independently, in either order or in the same cycle. Address, data and strobes are latched into hold registers.
  - Commit: on the first rising edge where aw_held && w_held, the register updates per WSTRB (lane n updates bits 8n+7:8n), BVALID is set, and both hold flags clear.
  - Latency: both accepted at edge k, commit and BVALID=1 at edge k+1.
  - BVALID holds until BVALID && BREADY; no new AW/W is accepted while BVALID is high.
  - WSTRB = 0 commits nothing but still responds OKAY.
- Read channel (single outstanding transaction):
  - ARREADY = !RVALID && !reset.
  - On an AR handshake at edge k: RDATA is loaded from the decoded slot and RVALID=1 after edge k.
  - RDATA and RVALID are held stable until RREADY; RVALID clears on the R handshake.
  - Back-to-back reads: the next ARREADY is high in the cycle after RVALID clears.
- Simultaneous read and write: the channels are independent. If a write commits to slot N at the same edge an AR for slot N is accepted, RDATA returns the pre-write value.
- Synchronisers: sw_in and btn_in each pass through a 2-flop synchroniser; a read reflects an input change 2-3 clocks later.
- ctrl_regs is updated on the commit edge.
- Reset asserted mid-transaction: all hold flags, BVALID and RVALID clear immediately. No response is issued for the aborted transaction.

Test Plan:
1. Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x00/0x04/0x08/0x0C, reading back after each write -> every BRESP and RRESP = 00; readback matches; ctrl_regs = {BEEF0011, DEAD0011, ABCD0001, 0101FFFF}.
2. Assert WVALID 3 cycles before AWVALID; separately, assert AWVALID 3 cycles before WVALID -> each commits one edge after the later handshake; BVALID asserts exactly once.
3. reg1 = 0xABCD0001, then write 0x12345678 with WSTRB = 4'b0101 -> reg1 reads 0xAB340078.
4. sw_in = 16'hA5C3, btn_in = 5'b10010, wait 3 clocks -> read 0x10 = 0x0000A5C3 and 0x14 = 0x00000012. A write of 0xFFFFFFFF to 0x10 leaves that readback unchanged with BRESP = 00.
5. Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA stay stable; AWREADY, WREADY and ARREADY stay low; a new AW is accepted only after the B handshake.
6. Assert reset after AW is accepted but before W -> AWREADY/WREADY low during reset; after release, no BVALID appears and reg0-3 = 0; a fresh write completes normally.
